spi_master: RTL
===============

Name: spi_master

Overview:
SPI initiator (mode 0, MSB first) that drives sclk/cs/mosi toward our SPI peripheral and samples miso back. It pairs with the peripheral's conditioned-input front end, so sclk is slow relative to clk. It accepts one word per valid/ready handshake, shifts it out full-duplex, and returns the received word with a one-cycle valid strobe.

Parameters:
DATAWIDTH, 8, bits per transfer
HALFPERIOD, 8, sclk half-period in clk cycles; must be >= 6 to clear the peripheral's 2-flop sync plus 3-cycle debounce plus edge register
CS_HOLD, 8, clk cycles cs stays low after the last sclk falling edge
CS_IDLE, 8, minimum clk cycles cs stays high between transfers
CNTWIDTH, 4, width of the timing counter; must hold max(HALFPERIOD, CS_HOLD, CS_IDLE)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
tx_data  input  DATAWIDTH  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word
rx_data  output  DATAWIDTH  last received word; held until next rx_valid
rx_valid  output  1  one-cycle strobe, rx_data updated
sclk  output  1  SPI clock, idles low
cs  output  1  chip select, active-low, idles high
mosi  output  1  serial out
miso  input  1  serial in, asynchronous to clk

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- All outputs registered. Reset values: sclk=0, cs=1, mosi=0, tx_ready=0, rx_valid=0, rx_data=0. Internal miso synchronizer flops reset to 0. State returns to IDLE.
- tx_ready goes to 1 on the first clk edge after rst_n deasserts.
- miso goes through a 2-flop synchronizer; only the synced value is sampled.
- States: IDLE, LOW, HIGH, HOLD, GAP.
- IDLE: tx_ready=1. If tx_valid&&tx_ready at edge T0, latch tx_data. At T0+1: cs=0, mosi=tx_data[DATAWIDTH-1], sclk=0, tx_ready=0. Go to LOW with bit index 0.
- LOW: sclk=0 for HALFPERIOD cycles, then sclk=1 and go to HIGH.
- HIGH: sclk=1 for HALFPERIOD cycles. On the last HIGH cycle, shift synced miso into the rx shift register LSB (late sample, which absorbs peripheral latency). Next edge sets sclk=0.
  - If bits remain, mosi advances to the next bit on that same edge and the state goes to LOW.
  - After bit DATAWIDTH-1, go to HOLD.
- HOLD: cs stays 0 for CS_HOLD cycles. The edge that leaves HOLD sets cs=1, rx_data=shift register, rx_valid=1 for exactly one cycle, and mosi=0. Go to GAP.
- GAP: cs=1 for CS_IDLE cycles, then tx_ready=1 and go to IDLE.
- Cycle timing: first sclk rise at T0+1+HALFPERIOD; last fall at T0+1+2*HALFPERIOD*DATAWIDTH; cs rises CS_HOLD cycles after the last fall.
- tx_valid outside IDLE is ignored. tx_data is sampled only at handshake.
- Counters wrap to 0 on each state change; no other wrap exists.
- rst_n low mid-transfer: all outputs go to reset values immediately (cs releases, sclk low). The partial rx word is discarded and rx_valid does not fire.

Optional Feature:
SPI_BURST_EN.
- Defined: on the last HOLD cycle, tx_ready=1. If tx_valid is high then, the new word is latched. cs stays 0, GAP is skipped, and the state goes to LOW with mosi=new MSB. rx_valid still pulses for the finished word.
- Undefined: every word gets its own cs frame, exactly as above.

Test Plan:
1. Reset, then send tx_data=0xA5 with a miso loopback model (peripheral returns 0x3C) -> mosi bits 1,0,1,0,0,1,0,1 stable at each sclk rise; rx_data=0x3C; rx_valid is a single cycle.
2. Timing check with HALFPERIOD=8, CS_HOLD=8, handshake at cycle 10 -> cs falls at 11, first sclk rise at 19, last fall at 139, cs rises at 147 with rx_valid, tx_ready at 155.
3. Assert rst_n low during bit 4 -> cs=1, sclk=0, mosi=0 asynchronously; no rx_valid; next transfer of 0xFF completes correctly.
4. Hold tx_valid high continuously with data 0x01 then 0x80 -> two separate cs frames with >= CS_IDLE high cycles between; second frame starts only after tx_ready.
5. Toggle miso asynchronously mid-HIGH phase -> captured bit equals the synced level on the last HIGH cycle; no metastability propagates to rx_data.
6. SPI_BURST_EN defined, words 0x12, 0x34 back-to-back -> cs stays low across 16 sclk cycles; rx_valid pulses twice with 0x12 and 0x34 echoed data.

Source files
------------

// File: rtl/spi_master.sv
// SPI initiator, mode 0, MSB first, full duplex; one word per valid/ready handshake.
// Optional SPI_BURST_EN: chain the next word into the same cs frame when offered at the end of HOLD.
module spi_master #(
    parameter int DATAWIDTH  = 8,
    parameter int HALFPERIOD = 8,
    parameter int CS_HOLD    = 8,
    parameter int CS_IDLE    = 8,
    parameter int CNTWIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATAWIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 sclk,
    output logic                 cs,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CNTWIDTH-1:0] HP_LAST   = CNTWIDTH'(HALFPERIOD - 1);
    localparam logic [CNTWIDTH-1:0] HOLD_LAST = CNTWIDTH'(CS_HOLD - 1);
    localparam logic [CNTWIDTH-1:0] IDLE_LAST = CNTWIDTH'(CS_IDLE - 1);
    localparam logic [BW-1:0]       BIT_LAST  = BW'(DATAWIDTH - 1);

    // state | meaning:  IDLE ready / launch frame,  LOW sclk low,  HIGH sclk high + late miso sample,
    //                   HOLD cs held after last fall,  GAP cs high idle time
    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

    state_t                state;
    logic [CNTWIDTH-1:0]   cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATAWIDTH-1:0]  tx_shift;
    logic [DATAWIDTH-1:0]  rx_shift;
    logic                  start;
    logic                  miso_meta;
    logic                  miso_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            start    <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            cs       <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // the handshake edge only latches; the frame opens one edge later
                    if (start) begin
                        start    <= 1'b0;
                        cs       <= 1'b0;
                        mosi     <= tx_shift[DATAWIDTH-1];
                        tx_shift <= tx_shift << 1;
                        bit_idx  <= '0;
                        cnt      <= '0;
                        state    <= LOW;
                    end else if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        tx_ready <= 1'b0;
                        start    <= 1'b1;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == HP_LAST) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == HP_LAST) begin
                        cnt      <= '0;
                        sclk     <= 1'b0;
                        rx_shift <= {rx_shift[DATAWIDTH-2:0], miso_sync};
                        if (bit_idx == BIT_LAST) begin
                            state <= HOLD;
`ifdef SPI_BURST_EN
                            tx_ready <= (CS_HOLD == 1);
`endif
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            mosi     <= tx_shift[DATAWIDTH-1];
                            tx_shift <= tx_shift << 1;
                            state    <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
`ifdef SPI_BURST_EN
                        tx_ready <= 1'b0;
                        if (tx_valid) begin
                            mosi     <= tx_data[DATAWIDTH-1];
                            tx_shift <= tx_data << 1;
                            bit_idx  <= '0;
                            state    <= LOW;
                        end else begin
                            cs    <= 1'b1;
                            mosi  <= 1'b0;
                            state <= GAP;
                        end
`else
                        cs    <= 1'b1;
                        mosi  <= 1'b0;
                        state <= GAP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
`ifdef SPI_BURST_EN
                        tx_ready <= (cnt == CNTWIDTH'(CS_HOLD - 2));
`endif
                    end
                end
                GAP: begin
                    if (cnt == IDLE_LAST) begin
                        cnt      <= '0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
